// File: rtl/rasterizer_mem_arbiter_if.sv
// Avalon-MM style request/response bundle shared by the rasterizer requesters
// and the SDRAM bridge port of rasterizer_mem_arbiter.
interface rasterizer_mem_arbiter_if #(
    parameter int ADDR_W = 26
);
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [3:0]        byteenable;
    logic [31:0]       writedata;
    logic              waitrequest;
    logic [31:0]       readdata;
    logic              readdatavalid;

    modport master (
        output address, read, write, byteenable, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, byteenable, writedata,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/rasterizer_mem_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM master between vertex fetch (m0) and pixel/z writer (m1).
// Define ARB_STATS_EN to enable the grant/stall statistics counters (otherwise tied to zero).
module rasterizer_mem_arbiter #(
    parameter int ADDR_W         = 26,
    parameter int TAG_DEPTH_LOG2 = 4,
    parameter int HOLD_MAX       = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    rasterizer_mem_arbiter_if.slave  m0_if,
    rasterizer_mem_arbiter_if.slave  m1_if,
    rasterizer_mem_arbiter_if.master s_if,
    output logic                     err_unexpected_rdv,
    output logic [31:0]              stat_grants0,
    output logic [31:0]              stat_grants1,
    output logic [31:0]              stat_stall_cycles
);
    localparam int DEPTH  = 1 << TAG_DEPTH_LOG2;
    localparam int HOLD_W = $clog2(HOLD_MAX + 1);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    state_t                    state_q;
    logic                      last_grant_q;
    logic [HOLD_W-1:0]         hold_cnt_q;
    logic [TAG_DEPTH_LOG2-1:0] wr_ptr_q;
    logic [TAG_DEPTH_LOG2-1:0] rd_ptr_q;
    logic [TAG_DEPTH_LOG2:0]   count_q;
    logic                      err_q;
    logic                      tag_mem [DEPTH];

    logic              granted, sel, pend0, pend1, other_pend;
    logic              req_rd, req_wr, fifo_full, fifo_empty, read_block;
    logic              accepted, push, pop_ok, pop_tag, hold_hit, stalled, release_grant;
    logic              grant0_start, grant1_start;
    logic [ADDR_W-1:0] addr_mux;

    assign granted    = (state_q != IDLE);
    assign sel        = (state_q == GRANT1);
    assign pend0      = m0_if.read | m0_if.write;
    assign pend1      = m1_if.read | m1_if.write;
    assign other_pend = sel ? pend0 : pend1;
    assign req_rd     = sel ? m1_if.read  : m0_if.read;
    assign req_wr     = sel ? m1_if.write : m0_if.write;

    assign fifo_full  = (count_q == (TAG_DEPTH_LOG2+1)'(DEPTH));
    assign fifo_empty = (count_q == '0);
    // A full tag FIFO only holds back reads; writes produce no return and pass through.
    assign read_block = granted & fifo_full & req_rd;

    assign addr_mux          = sel ? m1_if.address : m0_if.address;
    assign s_if.address      = addr_mux;
    assign s_if.byteenable   = sel ? m1_if.byteenable : m0_if.byteenable;
    assign s_if.writedata    = sel ? m1_if.writedata  : m0_if.writedata;
    assign s_if.read         = granted & req_rd & ~read_block;
    assign s_if.write        = granted & req_wr;

    assign m0_if.waitrequest = (state_q == GRANT0) ? (s_if.waitrequest | read_block) : 1'b1;
    assign m1_if.waitrequest = (state_q == GRANT1) ? (s_if.waitrequest | read_block) : 1'b1;

    assign accepted = (s_if.read | s_if.write) & ~s_if.waitrequest;
    assign push     = s_if.read & ~s_if.waitrequest;
    assign pop_ok   = s_if.readdatavalid & ~fifo_empty;
    assign pop_tag  = tag_mem[rd_ptr_q];

    assign m0_if.readdatavalid = pop_ok & ~pop_tag;
    assign m1_if.readdatavalid = pop_ok &  pop_tag;
    assign m0_if.readdata      = s_if.readdata;
    assign m1_if.readdata      = s_if.readdata;

    // The transfer that brings the count to HOLD_MAX completes in the release cycle itself.
    assign hold_hit      = (hold_cnt_q == HOLD_W'(HOLD_MAX)) |
                           (accepted & (hold_cnt_q == HOLD_W'(HOLD_MAX - 1)));
    assign stalled       = s_if.waitrequest & (req_rd | req_wr);
    assign release_grant = granted & ~stalled & (~(req_rd | req_wr) | (hold_hit & other_pend));

    assign grant0_start  = (state_q == IDLE) & pend0 & (~pend1 | last_grant_q);
    assign grant1_start  = (state_q == IDLE) & pend1 & ~grant0_start;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            hold_cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant0_start)      state_q <= GRANT0;
                    else if (grant1_start) state_q <= GRANT1;
                end
                default: begin
                    if (release_grant) begin
                        state_q      <= IDLE;
                        last_grant_q <= sel;
                        hold_cnt_q   <= '0;
                    end else if (accepted && hold_cnt_q != HOLD_W'(HOLD_MAX)) begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) tag_mem[wr_ptr_q] <= sel;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (push)   wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (s_if.readdatavalid && fifo_empty) err_q <= 1'b1;
        end
    end

    assign err_unexpected_rdv = err_q;

`ifdef ARB_STATS_EN
    logic [31:0] grants0_q, grants1_q, stall_q;
    logic        stall_any;

    assign stall_any = (pend0 & m0_if.waitrequest) | (pend1 & m1_if.waitrequest);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            grants0_q <= '0;
            grants1_q <= '0;
            stall_q   <= '0;
        end else begin
            if (grant0_start && grants0_q != '1) grants0_q <= grants0_q + 1'b1;
            if (grant1_start && grants1_q != '1) grants1_q <= grants1_q + 1'b1;
            if (stall_any && stall_q != '1)      stall_q   <= stall_q + 1'b1;
        end
    end

    assign stat_grants0      = grants0_q;
    assign stat_grants1      = grants1_q;
    assign stat_stall_cycles = stall_q;
`else
    assign stat_grants0      = '0;
    assign stat_grants1      = '0;
    assign stat_stall_cycles = '0;
`endif
endmodule

// File: tb/tb_rasterizer_mem_arbiter.sv
// Scoreboard bench for rasterizer_mem_arbiter: directed bursts, a behavioural SDRAM slave,
// and a monitor that checks every bus transfer and every routed read return.
module tb_rasterizer_mem_arbiter;
    localparam int AW  = 26;
    localparam int LAT = 3;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    rasterizer_mem_arbiter_if #(.ADDR_W(AW)) m0_bus ();
    rasterizer_mem_arbiter_if #(.ADDR_W(AW)) m1_bus ();
    rasterizer_mem_arbiter_if #(.ADDR_W(AW)) s_bus ();

    logic        err;
    logic [31:0] st_g0, st_g1, st_stall;

    rasterizer_mem_arbiter #(.ADDR_W(AW), .TAG_DEPTH_LOG2(4), .HOLD_MAX(16)) dut (
        .clock              (clock),
        .reset              (reset),
        .m0_if              (m0_bus),
        .m1_if              (m1_bus),
        .s_if               (s_bus),
        .err_unexpected_rdv (err),
        .stat_grants0       (st_g0),
        .stat_grants1       (st_g1),
        .stat_stall_cycles  (st_stall)
    );

    logic [AW-1:0] m_addr [2];
    logic          m_rd   [2];
    logic          m_wr   [2];
    logic [31:0]   m_wd   [2];
    logic          slv_wait, slv_rdv, hold_rdv, rand_wait, bogus;
    logic [31:0]   slv_data;

    assign m0_bus.address    = m_addr[0];
    assign m0_bus.read       = m_rd[0];
    assign m0_bus.write      = m_wr[0];
    assign m0_bus.writedata  = m_wd[0];
    assign m0_bus.byteenable = 4'hF;
    assign m1_bus.address    = m_addr[1];
    assign m1_bus.read       = m_rd[1];
    assign m1_bus.write      = m_wr[1];
    assign m1_bus.writedata  = m_wd[1];
    assign m1_bus.byteenable = 4'hF;
    assign s_bus.waitrequest   = slv_wait;
    assign s_bus.readdata      = slv_data;
    assign s_bus.readdatavalid = slv_rdv;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
    } bus_t;

    bus_t        exp_bus [$];
    logic [31:0] exp_rd0 [$];
    logic [31:0] exp_rd1 [$];
    int          slv_due [$];
    logic [31:0] slv_dat [$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int fw0, fw1;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] rdata(input logic [AW-1:0] a);
        return 32'hC0DE_0000 ^ {6'd0, a};
    endfunction

    function automatic logic [31:0] wdata(input logic [AW-1:0] a);
        return 32'h5A5A_0000 ^ {6'd0, a};
    endfunction

    function automatic logic m_wait(input int n);
        return (n == 0) ? m0_bus.waitrequest : m1_bus.waitrequest;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic exp_burst(input int n, input logic [AW-1:0] base, input int count, input bit wr);
        for (int i = 0; i < count; i++) begin
            exp_bus.push_back({wr, base + AW'(4 * i)});
            if (!wr) begin
                if (n == 0) exp_rd0.push_back(rdata(base + AW'(4 * i)));
                else        exp_rd1.push_back(rdata(base + AW'(4 * i)));
            end
        end
    endtask

    // Avalon master: holds the request, advancing the address after each accepted beat.
    task automatic run_master(input int n, input logic [AW-1:0] base, input int count,
                              input bit wr, output int first_wait);
        int i = 0;
        int guard = 0;
        int waits = 0;
        bit acc;
        m_rd[n] = !wr;
        m_wr[n] = wr;
        while (i < count && guard < 3000) begin
            m_addr[n] = base + AW'(4 * i);
            m_wd[n]   = wdata(m_addr[n]);
            @(negedge clock);
            acc = !m_wait(n);
            if (i == 0 && !acc) waits++;
            tick();
            if (acc) i++;
            guard++;
        end
        m_rd[n] = 1'b0;
        m_wr[n] = 1'b0;
        if (i < count) begin
            checks++;
            failures++;
            $display("FAIL master%0d_timeout actual=%0d beats required=%0d", n, i, count);
        end
        first_wait = waits;
    endtask

    task automatic drain(input string tag);
        int g = 0;
        while ((exp_rd0.size() != 0 || exp_rd1.size() != 0 || slv_due.size() != 0) && g < 400) begin
            tick();
            g++;
        end
        repeat (2) tick();
        check({tag, "_rd0_left"}, 64'(exp_rd0.size()), 64'd0);
        check({tag, "_rd1_left"}, 64'(exp_rd1.size()), 64'd0);
        check({tag, "_bus_left"}, 64'(exp_bus.size()), 64'd0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        for (int n = 0; n < 2; n++) begin
            m_rd[n] = 1'b0; m_wr[n] = 1'b0; m_addr[n] = '0; m_wd[n] = '0;
        end
        slv_due.delete();
        slv_dat.delete();
        repeat (2) tick();
        reset = 1'b1;
    endtask

    // Behavioural SDRAM slave: fixed read latency, optional withholding, optional bogus return.
    initial begin
        slv_rdv = 1'b0; slv_data = '0; slv_wait = 1'b0;
        forever begin
            tick();
            slv_wait = rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;
            if (bogus) begin
                slv_rdv  = 1'b1;
                slv_data = 32'hDEAD_BEEF;
                bogus    = 1'b0;
            end else if (!hold_rdv && slv_due.size() != 0 && cyc >= slv_due[0]) begin
                slv_rdv  = 1'b1;
                slv_data = slv_dat.pop_front();
                void'(slv_due.pop_front());
            end else begin
                slv_rdv = 1'b0;
            end
        end
    end

    // Monitor: compares each accepted bus transfer and each routed return against the queues.
    initial begin
        bus_t e;
        forever begin
            @(negedge clock);
            if (reset) begin
                if ((s_bus.read || s_bus.write) && !s_bus.waitrequest) begin
                    $display("xfer %s addr=%0h", s_bus.write ? "wr" : "rd", s_bus.address);
                    checks++;
                    if (exp_bus.size() == 0) begin
                        failures++;
                        $display("FAIL bus_xfer actual=%0h required=none", s_bus.address);
                    end else begin
                        e = exp_bus.pop_front();
                        if (s_bus.write !== e.wr || s_bus.address !== e.addr ||
                            (e.wr && s_bus.writedata !== wdata(e.addr))) begin
                            failures++;
                            $display("FAIL bus_xfer actual=%0b/%0h/%0h required=%0b/%0h/%0h",
                                     s_bus.write, s_bus.address, s_bus.writedata,
                                     e.wr, e.addr, wdata(e.addr));
                        end
                    end
                    if (s_bus.read) begin
                        slv_due.push_back(cyc + LAT);
                        slv_dat.push_back(rdata(s_bus.address));
                    end
                end
                if (m0_bus.readdatavalid) begin
                    $display("ret m0 data=%0h", m0_bus.readdata);
                    checks++;
                    if (exp_rd0.size() == 0) begin
                        failures++;
                        $display("FAIL m0_return actual=%0h required=none", m0_bus.readdata);
                    end else if (m0_bus.readdata !== exp_rd0[0]) begin
                        failures++;
                        $display("FAIL m0_return actual=%0h required=%0h", m0_bus.readdata, exp_rd0[0]);
                        void'(exp_rd0.pop_front());
                    end else begin
                        void'(exp_rd0.pop_front());
                    end
                end
                if (m1_bus.readdatavalid) begin
                    $display("ret m1 data=%0h", m1_bus.readdata);
                    checks++;
                    if (exp_rd1.size() == 0) begin
                        failures++;
                        $display("FAIL m1_return actual=%0h required=none", m1_bus.readdata);
                    end else if (m1_bus.readdata !== exp_rd1[0]) begin
                        failures++;
                        $display("FAIL m1_return actual=%0h required=%0h", m1_bus.readdata, exp_rd1[0]);
                        void'(exp_rd1.pop_front());
                    end else begin
                        void'(exp_rd1.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        hold_rdv = 1'b0; rand_wait = 1'b0; bogus = 1'b0;
        do_reset();

        // Reset state
        @(negedge clock);
        check("rst_m0_wait", 64'(m0_bus.waitrequest), 64'd1);
        check("rst_m1_wait", 64'(m1_bus.waitrequest), 64'd1);
        check("rst_s_read",  64'(s_bus.read), 64'd0);
        check("rst_s_write", 64'(s_bus.write), 64'd0);
        check("rst_m0_rdv",  64'(m0_bus.readdatavalid), 64'd0);
        check("rst_m1_rdv",  64'(m1_bus.readdatavalid), 64'd0);
        check("rst_err",     64'(err), 64'd0);
        check("rst_stat_g0", 64'(st_g0), 64'd0);
        tick();

        // m0 alone: 15-word read burst, granted one cycle after the request
        exp_burst(0, 26'h100, 15, 1'b0);
        run_master(0, 26'h100, 15, 1'b0, fw0);
        check("t1_grant_latency", 64'(fw0), 64'd1);
        drain("t1");

        // Tie after reset goes to m0, then m1, then m0 again on the next tie
        do_reset();
        rand_wait = 1'b1;
        exp_burst(0, 26'h200, 2, 1'b0);
        exp_burst(1, 26'h300, 2, 1'b0);
        fork
            run_master(0, 26'h200, 2, 1'b0, fw0);
            run_master(1, 26'h300, 2, 1'b0, fw1);
        join
        repeat (3) tick();
        exp_burst(0, 26'h208, 1, 1'b0);
        exp_burst(1, 26'h308, 1, 1'b0);
        fork
            run_master(0, 26'h208, 1, 1'b0, fw0);
            run_master(1, 26'h308, 1, 1'b0, fw1);
        join
        rand_wait = 1'b0;
        drain("t2");

        // Hold limit: m0 forced off after 16 beats while m1 waits with writes
        exp_burst(0, 26'h1000, 16, 1'b0);
        exp_burst(1, 26'h2000, 2, 1'b1);
        exp_burst(0, 26'h1040, 24, 1'b0);
        fork
            run_master(0, 26'h1000, 40, 1'b0, fw0);
            begin
                repeat (4) tick();
                run_master(1, 26'h2000, 2, 1'b1, fw1);
            end
        join
        drain("t3");

        // Tag FIFO full: 17th read blocked until the first return
        hold_rdv = 1'b1;
        exp_burst(0, 26'h3000, 17, 1'b0);
        fork
            run_master(0, 26'h3000, 17, 1'b0, fw0);
            begin
                repeat (25) tick();
                @(negedge clock);
                check("t4_rd_pending",   64'(m_rd[0]), 64'd1);
                check("t4_m0_wait",      64'(m0_bus.waitrequest), 64'd1);
                check("t4_s_read_block", 64'(s_bus.read), 64'd0);
                check("t4_beats_left",   64'(exp_bus.size()), 64'd1);
                hold_rdv = 1'b0;
            end
        join
        drain("t4");

        // Returns arriving after the grant switch are routed by tag
        hold_rdv = 1'b1;
        exp_burst(0, 26'h4000, 2, 1'b0);
        exp_burst(1, 26'h5000, 2, 1'b0);
        run_master(0, 26'h4000, 2, 1'b0, fw0);
        run_master(1, 26'h5000, 2, 1'b0, fw1);
        repeat (3) tick();
        hold_rdv = 1'b0;
        drain("t5");

        // Unexpected readdatavalid sets the sticky error; async reset clears it
        @(negedge clock);
        check("t6_err_before", 64'(err), 64'd0);
        bogus = 1'b1;
        repeat (3) tick();
        @(negedge clock);
        check("t6_err_set", 64'(err), 64'd1);
        tick();
        #2;
        reset = 1'b0;
        #1;
        check("t6_err_cleared", 64'(err), 64'd0);
        check("t6_m0_wait",     64'(m0_bus.waitrequest), 64'd1);
        check("t6_m1_wait",     64'(m1_bus.waitrequest), 64'd1);
        repeat (2) tick();
        reset = 1'b1;
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
